// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Turns a registered-read dual-port RAM into a first-word-fall-through FIFO
//   with valid/ready handshakes on both sides. The RAM's one-cycle read
//   latency is hidden by an output register plus a one-entry skid register,
//   so a continuous stream moves one word per cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_data/valid     producer word and handshake; in_ready back to producer
//   out_data/valid    oldest word (registered); out_ready from consumer
//   count             words held (accepted minus delivered), 0..RAM_SIZE
//   ram_w_*           RAM write port (combinational from the push)
//   ram_r_addr        RAM read address; ram_data_out valid one cycle later
module ram_fifo_ctrl #(
    parameter int RAM_SIZE   = 64,
    parameter int DATA_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_w_enable,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH:0]   FULL    = RAM_SIZE[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  pend_q, pend_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic       push, pop, fetch;
    logic [2:0] occ;

    // Full is judged on the registered count only: a pop at full frees the
    // slot for the next cycle, keeping in_ready off the pop path.
    assign in_ready     = !rst && (count_q != FULL);
    assign ram_w_enable = push;
    assign ram_w_addr   = wr_ptr_q;
    assign ram_data_in  = in_data;
    assign ram_r_addr   = rd_ptr_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign count        = count_q;

    always_comb begin
        push = in_valid && in_ready;
        pop  = out_valid_q && out_ready;
        // Words that will sit in the output stages after this edge if no new
        // fetch is issued; a fetch is allowed only while there is room for it.
        occ   = {2'b0, out_valid_q} + {2'b0, skid_valid_q} + {2'b0, pend_q} - {2'b0, pop};
        // mem_count is registered, so a word written this cycle cannot be
        // fetched until next cycle: no same-address read/write collision.
        fetch = (mem_count_q != '0) && (occ < 3'd2);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_count_d  = mem_count_q;
        count_d      = count_q;
        pend_d       = fetch;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (fetch) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !fetch) mem_count_d = mem_count_q + CNT_ONE;
        if (!push && fetch) mem_count_d = mem_count_q - CNT_ONE;
        if (push && !pop)   count_d = count_q + CNT_ONE;
        if (!push && pop)   count_d = count_q - CNT_ONE;

        // Order-preserving refill: skid drains into the output register
        // before any newly returned RAM word.
        if (pop && skid_valid_q) begin
            out_data_d = skid_q;
            if (pend_q) skid_d = ram_data_out;
            else        skid_valid_d = 1'b0;
        end else if (pop) begin
            if (pend_q) out_data_d  = ram_data_out;
            else        out_valid_d = 1'b0;
        end else if (pend_q) begin
            if (!out_valid_q) begin
                out_data_d  = ram_data_out;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = ram_data_out;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            count_q      <= '0;
            pend_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
    localparam int RS = 64;
    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   count;
    logic [AW-1:0] ram_w_addr;
    logic          ram_w_enable;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_r_addr;
    logic [DW-1:0] ram_data_out;

    ram_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count),
        .ram_w_addr(ram_w_addr), .ram_w_enable(ram_w_enable), .ram_data_in(ram_data_in),
        .ram_r_addr(ram_r_addr), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Registered-read RAM attached to the controller.
    logic [DW-1:0] mem [RS];
    always @(posedge clk) begin
        if (ram_w_enable) mem[ram_w_addr] <= ram_data_in;
        ram_data_out <= mem[ram_r_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: expected contents in order, occupancy, write pointer.
    logic [DW-1:0] expq [$];
    int            m_count = 0;
    int            m_wptr  = 0;
    bit            hold    = 0;
    logic [DW-1:0] held;
    bit            s_push, s_pop, s_ov;
    logic [DW-1:0] s_od;
    int            s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the cycle against the model,
    // advance the model, then step past the edge.
    task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit exp_push;
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        exp_push = iv && !rst && (m_count != RS);
        chk("in_ready", in_ready, !rst && (m_count != RS));
        chk("count", count, m_count);
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held);
        end
        chk("w_enable", ram_w_enable, exp_push);
        if (exp_push) begin
            chk("w_addr", ram_w_addr, m_wptr);
            chk("w_data", ram_data_in, d);
        end
        if (out_valid === 1'b1) begin
            if (expq.size() == 0) chk("valid_when_empty", out_valid, 0);
            else                  chk("out_data", out_data, expq[0]);
        end
        s_push = iv && in_ready;
        s_pop  = (out_valid === 1'b1) && ordy;
        s_ov   = out_valid;
        s_od   = out_data;
        s_cnt  = count;
        if (s_pop && expq.size() > 0) begin
            void'(expq.pop_front());
            m_count--;
        end
        if (exp_push) begin
            expq.push_back(d);
            m_wptr = (m_wptr + 1) % RS;
            m_count++;
        end
        hold = (out_valid === 1'b1) && !ordy;
        held = out_data;
        @(posedge clk);
        #1;
        if (rst) begin
            expq.delete();
            m_count = 0;
            m_wptr  = 0;
            hold    = 0;
        end
    endtask

    task automatic drain(output int pops);
        int n;
        n = 0;
        pops = 0;
        while (expq.size() > 0 && n < 400) begin
            cyc(0, '0, 1);
            pops += int'(s_pop);
            n++;
        end
        chk("drain_done", expq.size(), 0);
        cyc(0, '0, 1);
        chk("drain_idle", s_ov, 0);
    endtask

    initial begin
        int pops, mx, sent, n;
        logic [7:0] v;

        // Reset: in_ready and write strobe held low even with in_valid high.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h11;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_w_enable", ram_w_enable, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_in_ready", in_ready, 1);

        // Single word: visible three cycles after the push.
        cyc(1, 8'hA5, 1);
        cyc(0, '0, 1); chk("sw_ov_c1", s_ov, 0);
        cyc(0, '0, 1); chk("sw_ov_c2", s_ov, 0);
        cyc(0, '0, 1); chk("sw_ov_c3", s_ov, 1); chk("sw_data_c3", s_od, 8'hA5);
        cyc(0, '0, 1); chk("sw_ov_c4", s_ov, 0); chk("sw_cnt_c4", s_cnt, 0);

        // Fill to full, refuse a 65th word, then drain in order.
        for (int i = 0; i < RS; i++) begin
            v = i[7:0];
            cyc(1, v, 0);
        end
        cyc(1, 8'h40, 0);
        chk("fill_cnt", s_cnt, RS);
        chk("fill_refused", s_push, 0);
        drain(pops);
        chk("fill_pops", pops, RS);

        // Streaming: 200 words, one per cycle after the fill latency.
        pops = 0; mx = 0;
        for (int i = 0; i < 200; i++) begin
            v = i[7:0];
            cyc(1, v, 1);
            pops += int'(s_pop);
            if (s_cnt > mx) mx = s_cnt;
        end
        chk("stream_pops", pops, 197);
        chk("stream_max_cnt_le3", mx <= 3, 1);
        drain(pops);
        chk("stream_tail", pops, 3);

        // Backpressure: random consumer and producer over 500 words.
        sent = 0; n = 0;
        while (sent < 500 && n < 5000) begin
            v = sent[7:0];
            cyc($urandom_range(0, 3) != 0, v, $urandom_range(0, 1) == 1);
            if (s_push) sent++;
            n++;
        end
        chk("bp_sent", sent, 500);
        drain(pops);

        // Simultaneous push and pop at count 30.
        for (int i = 0; i < 30; i++) begin
            v = 8'(i + 50);
            cyc(1, v, 0);
        end
        cyc(0, '0, 0); cyc(0, '0, 0); cyc(0, '0, 0);
        chk("pp_cnt_before", s_cnt, 30);
        cyc(1, 8'hEE, 1);
        chk("pp_both", s_push && s_pop, 1);
        cyc(0, '0, 0);
        chk("pp_cnt_after", s_cnt, 30);
        drain(pops);
        chk("pp_pops", pops, 30);

        // Reset at count 20 with a fetch in flight.
        for (int i = 0; i < 20; i++) begin
            v = 8'(i + 100);
            cyc(1, v, 0);
        end
        cyc(0, '0, 0); cyc(0, '0, 0); cyc(0, '0, 0);
        cyc(1, 8'h77, 1);
        chk("mr_cnt", s_cnt, 20);
        rst = 1'b1;
        cyc(0, '0, 0);
        rst = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_in_ready", in_ready, 1);
        cyc(1, 8'h3C, 0);
        n = 0;
        s_pop = 0;
        while (!s_pop && n < 20) begin
            cyc(0, '0, 1);
            n++;
        end
        chk("mr_first_popped", s_pop, 1);
        chk("mr_first_word", s_od, 8'h3C);
        cyc(0, '0, 1);
        chk("mr_idle", s_ov, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

- Controller that turns the registered-read dual-port `ram` into a first-word-fall-through FIFO with valid/ready on both sides.
- Sits between a producer and a consumer and drives the RAM's write port and read port directly.
- Hides the RAM's 1-cycle read latency with an output register plus a skid register, so a continuous stream flows at one word per cycle.
- Total occupancy (RAM, in-flight read, output stages) never exceeds RAM_SIZE.

## Interface
- RAM_SIZE, 64: FIFO depth in words; must match the attached RAM; power of two, ≥ 2.
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, $clog2(RAM_SIZE): localparam, RAM address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_data  in  DATA_WIDTH  producer word.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- out_data  out  DATA_WIDTH  oldest word (output register).
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer takes out_data this cycle.
- count  out  ADDR_WIDTH+1  words held (accepted minus delivered), 0..RAM_SIZE.
- ram_w_addr  out  ADDR_WIDTH  RAM write address.
- ram_w_enable  out  1  RAM write strobe.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_r_addr  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_r_addr.

## Operation

**Events**
- push = in_valid & in_ready.
- pop = out_valid & out_ready.

**Write side**
- in_ready = !rst & (count != RAM_SIZE). This uses the registered count only, so a pop at full does not allow a push in the same cycle.
- ram_w_enable = push, ram_w_addr = wr_ptr, ram_data_in = in_data (all combinational).
- wr_ptr increments on push and wraps modulo RAM_SIZE.

**Read side**
- mem_count (ADDR_WIDTH+1 bits) = words written to RAM but not yet fetched.
- ram_r_addr = rd_ptr (combinational).
- occ = out_valid + skid_valid + pend − pop.
- fetch = (mem_count != 0) & (occ < 2).
- On fetch: rd_ptr increments (wraps modulo RAM_SIZE), and pend is set to 1 for the next cycle.
- pend = 1 means ram_data_out is valid this cycle and is captured at this cycle's edge.
- mem_count update: +push −fetch. A push into an empty RAM is not fetched in the same cycle, because mem_count is registered. This rules out read/write collisions on one address.

**Output stage update (order preserving)**
- pop & skid_valid: out_data ← skid; if pend, skid ← ram_data_out; otherwise skid_valid ← 0.
- pop & !skid_valid: if pend, out_data ← ram_data_out; otherwise out_valid ← 0.
- !pop & pend: if !out_valid, out_data ← ram_data_out and out_valid ← 1; otherwise skid ← ram_data_out and skid_valid ← 1. The fetch rule guarantees the skid is empty here.
- count update: +push −pop. Simultaneous push and pop leaves count unchanged.

**Reset**
- While rst: wr_ptr, rd_ptr, mem_count, pend, skid_valid, out_valid, count, out_data, skid ← 0.
- in_ready = 0 and ram_w_enable = 0 during reset. RAM contents are not cleared.
- Reset mid-stream discards all stored and in-flight words. In-flight ram_data_out is ignored.
- The cycle after rst falls: in_ready = 1, out_valid = 0, count = 0.

## Timing
- Push to out_valid on an empty FIFO: 3 cycles.
  - push in cycle t.
  - fetch in t+1.
  - pend in t+2.
  - out_valid = 1 in t+3.
- Steady state with in_valid = out_ready = 1: one word per cycle in and out, after the initial 3-cycle fill.
- out_data and out_valid are stable while out_valid & !out_ready. Only a pop may change out_data.
- count reaches RAM_SIZE and in_ready drops on the cycle after the RAM_SIZE-th push.

## Test plan
- Single word: push 0xA5 at cycle 0 with out_ready=1 → out_valid=1 with out_data=0xA5 at cycle 3. At cycle 4: count=0, out_valid=0.
- Fill: push 0..63 with out_ready=0 → in_ready=0 after the 64th push and count=64. A 65th in_valid is not accepted (ram_w_enable=0). Draining then yields 0..63 in order, with in_ready=1 after the first pop.
- Streaming: continuous push of 0..199 with out_ready=1 → the output sequence equals the input sequence at one word per cycle after fill. Pointers wrap three times with no loss; count stays ≤ 3.
- Backpressure: random out_ready (~50%) over 500 words → no drops, duplicates or reordering. out_data is held while out_valid & !out_ready, and the skid register is exercised.
- Simultaneous push/pop at count=30 → count stays 30 and ordering is preserved.
- Reset mid-operation: assert rst at count=20 with a fetch in flight → the cycle after rst deasserts: out_valid=0, count=0, in_ready=1. The next word pushed is the first word out.
